// File: rtl/ureg_arbiter2.sv
// Two-to-one ureg arbiter: registered request slot, in-order ID FIFO for response routing.
// Define UREG_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 has fixed priority.
module ureg_arbiter2 #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        m0_req_val,
  output logic        m0_req_rdy,
  input  logic [11:0] m0_req_addr,
  input  logic [7:0]  m0_req_strb,
  input  logic [63:0] m0_req_data,
  output logic        m0_resp_val,
  input  logic        m0_resp_rdy,
  output logic [63:0] m0_resp_data,
  output logic        m0_resp_ecc,
  input  logic        m1_req_val,
  output logic        m1_req_rdy,
  input  logic [11:0] m1_req_addr,
  input  logic [7:0]  m1_req_strb,
  input  logic [63:0] m1_req_data,
  output logic        m1_resp_val,
  input  logic        m1_resp_rdy,
  output logic [63:0] m1_resp_data,
  output logic        m1_resp_ecc,
  output logic        ureg_req_val,
  input  logic        ureg_req_rdy,
  output logic [11:0] ureg_req_addr,
  output logic [7:0]  ureg_req_strb,
  output logic [63:0] ureg_req_data,
  input  logic        ureg_resp_val,
  output logic        ureg_resp_rdy,
  input  logic [63:0] ureg_resp_data,
  input  logic        ureg_resp_ecc,
  output logic        err_orphan
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Handshakes: a transfer happens on a rising edge where val && rdy; the sender holds
  // its payload stable while val && !rdy, and rdy never depends on the partner's rdy.

  logic                       req_val_q, req_val_d;
  logic [11:0]                req_addr_q, req_addr_d;
  logic [7:0]                 req_strb_q, req_strb_d;
  logic [63:0]                req_data_q, req_data_d;
  logic [MAX_OUTSTANDING-1:0] id_mem_q, id_mem_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       err_orphan_q, err_orphan_d;

  logic can_accept;
  logic gnt0;
  logic gnt1;
  logic push;
  logic pop;
  logic fifo_empty;
  logic head_id;

  assign fifo_empty = (count_q == '0);
  assign head_id    = id_mem_q[rd_ptr_q];

  // The full check uses the registered count, so a same-cycle pop never frees room.
  assign can_accept = !sys_rst && (!req_val_q || ureg_req_rdy) &&
                      (count_q < CNT_W'(MAX_OUTSTANDING));

`ifdef UREG_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  assign gnt0 = can_accept && m0_req_val && (!m1_req_val || last_q);
  assign gnt1 = can_accept && m1_req_val && (!m0_req_val || !last_q);

  always_comb begin
    last_d = last_q;
    if (gnt1)      last_d = 1'b1;
    else if (gnt0) last_d = 1'b0;
  end

  // Reset to "requester 1 granted last" so requester 0 wins the first tie.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`else
  assign gnt0 = can_accept && m0_req_val;
  assign gnt1 = can_accept && m1_req_val && !m0_req_val;
`endif

  assign push = gnt0 || gnt1;
  assign pop  = ureg_resp_val && ureg_resp_rdy && !fifo_empty;

  assign m0_req_rdy    = gnt0;
  assign m1_req_rdy    = gnt1;
  assign ureg_req_val  = req_val_q;
  assign ureg_req_addr = req_addr_q;
  assign ureg_req_strb = req_strb_q;
  assign ureg_req_data = req_data_q;

  // With nothing outstanding the response is orphaned: accept and drop it.
  assign ureg_resp_rdy = !sys_rst && (fifo_empty || (head_id ? m1_resp_rdy : m0_resp_rdy));
  assign m0_resp_val   = !sys_rst && !fifo_empty && !head_id && ureg_resp_val;
  assign m1_resp_val   = !sys_rst && !fifo_empty &&  head_id && ureg_resp_val;
  assign m0_resp_data  = ureg_resp_data;
  assign m1_resp_data  = ureg_resp_data;
  assign m0_resp_ecc   = ureg_resp_ecc;
  assign m1_resp_ecc   = ureg_resp_ecc;
  assign err_orphan    = err_orphan_q;

  always_comb begin
    req_val_d    = req_val_q;
    req_addr_d   = req_addr_q;
    req_strb_d   = req_strb_q;
    req_data_d   = req_data_q;
    id_mem_d     = id_mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    err_orphan_d = err_orphan_q || (fifo_empty && ureg_resp_val);

    if (push) begin
      req_val_d          = 1'b1;
      req_addr_d         = gnt1 ? m1_req_addr : m0_req_addr;
      req_strb_d         = gnt1 ? m1_req_strb : m0_req_strb;
      req_data_d         = gnt1 ? m1_req_data : m0_req_data;
      id_mem_d[wr_ptr_q] = gnt1;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
    end else if (req_val_q && ureg_req_rdy) begin
      req_val_d = 1'b0;
    end

    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      req_val_q    <= 1'b0;
      req_addr_q   <= '0;
      req_strb_q   <= '0;
      req_data_q   <= '0;
      id_mem_q     <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      req_val_q    <= req_val_d;
      req_addr_q   <= req_addr_d;
      req_strb_q   <= req_strb_d;
      req_data_q   <= req_data_d;
      id_mem_q     <= id_mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      err_orphan_q <= err_orphan_d;
    end
  end

endmodule
